scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Sequences the cube-scan pass by driving `spin_all`. For each step it requests a move batch, unpacks the 60-bit batch into single 4-bit move codes for the motor move queue, then requests a colour observation. It then advances to the next step. It sits between the top-level solve FSM (start/done), `spin_all`, the motor driver and the colour-sampling logic.

## Interface
Parameters:
- `NUM_STEPS`, 45: number of `spin_all` steps. Counter runs 0..NUM_STEPS-1.
- `MOVE_W`, 4: bits per move code.
- `MAX_MOVES`, 15: move slots per batch. The batch width is MOVE_W*MAX_MOVES = 60.
- `TIMEOUT_CYCLES`, 50_000_000: watchdog limit. Used only with SCAN_WATCHDOG_EN.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a scan. Ignored unless IDLE.
- `send_setup_moves` out 1: one-cycle request to `spin_all`.
- `counter` out 6: step index to `spin_all`.
- `new_moves` in 1: batch valid strobe from `spin_all`.
- `moves` in 60: packed batch. The first move is in the most-significant non-empty nibble.
- `move` out 4: move code to the motor queue.
- `move_valid` out 1: `move` is valid.
- `move_ready` in 1: the motor queue accepts `move`.
- `observe_req` out 1: request a colour sample of the current facelet.
- `observe_done` in 1: sample taken. Single-cycle pulse.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the scan completes.
- `timeout` out 1: sticky watchdog error. Present only with SCAN_WATCHDOG_EN.

## Operation
- States:
  - IDLE → REQ on `start`.
  - REQ → WAIT on the next edge.
  - WAIT → ISSUE on `new_moves`.
  - ISSUE → OBSERVE when no moves remain, if counter < NUM_STEPS-1.
  - ISSUE → FINISH when no moves remain, if counter = NUM_STEPS-1.
  - OBSERVE → REQ on `observe_done`, with counter+1.
  - FINISH → IDLE after one cycle, pulsing `done`.
- REQ asserts `send_setup_moves` for exactly one cycle. `counter` is held stable from REQ until the batch is captured.
- WAIT captures `moves` into the unpacker on the cycle `new_moves`=1. `new_moves` in any other state is ignored.
- The unpacker emits nibbles from MSB (nibble 14) to LSB (nibble 0).
  - Codes 0, 1, 14 and 15 are non-moves and are skipped silently. They cost no handshake cycle.
  - An all-skip batch goes straight from ISSUE to OBSERVE/FINISH on the next cycle.
- Handshake is valid/ready. A transfer occurs on an edge with `move_valid` && `move_ready`. `move` is stable while valid && !ready. At most one move transfers per cycle.
- `observe_req` stays high throughout OBSERVE and is cleared on the edge that samples `observe_done`. `observe_done` outside OBSERVE is ignored.
- The final step (counter = NUM_STEPS-1) is restore-only: its moves are issued, and there is no observation.
- `counter` resets to 0, increments only in OBSERVE→REQ, and returns to 0 on FINISH→IDLE. It never wraps past NUM_STEPS-1.
- Reset at any point returns to IDLE immediately and discards any partial batch.

## Timing
- Reset values: `send_setup_moves`=0, `counter`=0, `move`=0, `move_valid`=0, `observe_req`=0, `busy`=0, `done`=0, `timeout`=0.
- `start` at edge N: REQ in cycle N+1, with `send_setup_moves` high in that cycle.
- `spin_all` returns `new_moves` 2 cycles after the request. WAIT tolerates any latency.
- Capture at edge M: `move_valid` is high in cycle M+1 if the batch has any real move. It is zero-bubble between consecutive moves while `move_ready`=1.
- Last transfer at edge K: `observe_req` is high in cycle K+1.
- `observe_done` at edge J: the next REQ is in cycle J+1.
- All outputs are registered.

## Configuration
- `SCAN_WATCHDOG_EN` defined:
  - A counter runs in WAIT, ISSUE (while valid && !ready) and OBSERVE, and resets on each state change.
  - Reaching TIMEOUT_CYCLES sets sticky `timeout`, drops `move_valid` and `observe_req`, and goes to IDLE without `done`.
  - `timeout` clears on reset or the next accepted `start`.
- Undefined: no watchdog logic and no `timeout` port. The block waits indefinitely.

## Structure
- `rbot_pkg` holds:
  - move code constants R=2 … Di=13 and MOVE_NONE=0;
  - the `is_move()` range check;
  - the sequencer state enum.
- Sub-module `move_unpacker`: a 60-bit shift register plus skip logic, with ports `load`/`data` and `valid`/`ready`/`code`/`empty`. The sequencer FSM instantiates it once.

## Test plan
- Batch `{U}` = 60'h4 at step 1 → exactly one transfer of code 4, then `observe_req`. Counter 1 → 2 after `observe_done`.
- Batch 60'h0000_0000_0000_4_6_B (U,F,Bi) with `move_ready` toggling 1,0,1,1 → transfers 4, 6, 11 in order. `move` is stable during the stall.
- Batch 60'h0 → no `move_valid`. `observe_req` is high 2 cycles after capture.
- Full run with a `spin_all` model, with `observe_done` 3 cycles after each request → 44 observations, 45 requests, one `done` pulse, and counter back to 0.
- Reset asserted mid-ISSUE → all outputs are 0 immediately. The next `start` begins at counter 0.
- With SCAN_WATCHDOG_EN and TIMEOUT_CYCLES=100, `observe_done` withheld → `timeout`=1 at cycle 100 of OBSERVE, IDLE, and no `done`.

Source files
------------

// File: rtl/rbot_pkg.sv
// rbot_pkg: shared definitions for the cube-scan sequencer.
//   - move code constants (MV_R .. MV_DI, MV_NONE)
//   - is_move(): true for codes that drive the motors (2..13)
//   - seq_state_e: scan sequencer FSM states
package rbot_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] MV_NONE = 4'd0;
    localparam logic [CODE_W-1:0] MV_R    = 4'd2;
    localparam logic [CODE_W-1:0] MV_RI   = 4'd3;
    localparam logic [CODE_W-1:0] MV_U    = 4'd4;
    localparam logic [CODE_W-1:0] MV_UI   = 4'd5;
    localparam logic [CODE_W-1:0] MV_F    = 4'd6;
    localparam logic [CODE_W-1:0] MV_FI   = 4'd7;
    localparam logic [CODE_W-1:0] MV_L    = 4'd8;
    localparam logic [CODE_W-1:0] MV_LI   = 4'd9;
    localparam logic [CODE_W-1:0] MV_B    = 4'd10;
    localparam logic [CODE_W-1:0] MV_BI   = 4'd11;
    localparam logic [CODE_W-1:0] MV_D    = 4'd12;
    localparam logic [CODE_W-1:0] MV_DI   = 4'd13;

    // Codes outside R..Di (0, 1, 14, 15) are padding in a batch.
    function automatic logic is_move(input logic [CODE_W-1:0] c);
        return (c >= MV_R) && (c <= MV_DI);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ISSUE,
        ST_OBSERVE,
        ST_FINISH
    } seq_state_e;

endpackage

// File: rtl/move_unpacker.sv
// move_unpacker: holds one packed move batch and emits its real moves,
// most-significant slot first, over a valid/ready handshake.
//   load  in : capture data (overrides any handshake that cycle)
//   data  in : packed batch, MAX_MOVES slots of MOVE_W bits
//   valid out: code holds a real move (registered)
//   ready in : consumer accepts code this cycle
//   code  out: current move code, MV_NONE when nothing pending (registered)
//   empty out: no real move remains once this cycle's handshake completes
// A pending-slot mask marks the real moves; padding codes are never set in
// the mask, so they are skipped without costing a cycle.
module move_unpacker
    import rbot_pkg::*;
#(
    parameter int MOVE_W    = CODE_W,
    parameter int MAX_MOVES = 15
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic [MOVE_W*MAX_MOVES-1:0] data,
    output logic                        valid,
    input  logic                        ready,
    output logic [MOVE_W-1:0]           code,
    output logic                        empty
);

    logic [MOVE_W*MAX_MOVES-1:0] data_q, data_d;
    logic [MAX_MOVES-1:0]        pend_q, pend_d, top;
    logic                        valid_q;
    logic [MOVE_W-1:0]           code_q, code_d;

    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        top    = '0;
        code_d = MV_NONE;
        // one-hot of the highest pending slot = the move currently offered
        for (int i = 0; i < MAX_MOVES; i++)
            if (pend_q[i]) begin
                top    = '0;
                top[i] = 1'b1;
            end
        if (load) begin
            data_d = data;
            for (int i = 0; i < MAX_MOVES; i++)
                pend_d[i] = is_move(data[i*MOVE_W +: MOVE_W]);
        end else if (valid_q && ready) begin
            pend_d = pend_q & ~top;
        end
        // present the next move in the same edge, so transfers are back-to-back
        for (int i = 0; i < MAX_MOVES; i++)
            if (pend_d[i]) code_d = data_d[i*MOVE_W +: MOVE_W];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= MV_NONE;
        end else begin
            data_q  <= data_d;
            pend_q  <= pend_d;
            valid_q <= |pend_d;
            code_q  <= code_d;
        end
    end

    assign valid = valid_q;
    assign code  = code_q;
    assign empty = ~|pend_d;

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps spin_all through NUM_STEPS scan positions. Each step
// requests a move batch, streams its real moves to the motor queue, then
// requests a colour observation (the last step only restores, no observe).
//   clock, reset           : clock, async active-high reset
//   start                  : begin a scan (accepted only in IDLE)
//   send_setup_moves       : one-cycle batch request to spin_all
//   counter[5:0]           : current step index
//   new_moves, moves[59:0] : batch strobe and packed batch from spin_all
//   move, move_valid,
//   move_ready             : valid/ready stream to the motor move queue
//   observe_req,
//   observe_done           : colour sample request / completion pulse
//   busy, done             : not-IDLE flag, end-of-scan pulse
//   timeout                : sticky watchdog error (SCAN_WATCHDOG_EN only)
// Optional build macro SCAN_WATCHDOG_EN adds the TIMEOUT_CYCLES watchdog.
module scan_sequencer
    import rbot_pkg::*;
#(
    parameter int NUM_STEPS = 45,
    parameter int MOVE_W    = 4,
    parameter int MAX_MOVES = 15
`ifdef SCAN_WATCHDOG_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        send_setup_moves,
    output logic [5:0]                  counter,
    input  logic                        new_moves,
    input  logic [MOVE_W*MAX_MOVES-1:0] moves,
    output logic [MOVE_W-1:0]           move,
    output logic                        move_valid,
    input  logic                        move_ready,
    output logic                        observe_req,
    input  logic                        observe_done,
    output logic                        busy,
    output logic                        done
`ifdef SCAN_WATCHDOG_EN
   ,output logic                        timeout
`endif
);

    localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

    seq_state_e state_q, state_d;
    logic [5:0] counter_q, counter_d;
    logic       send_q, obs_q, busy_q, done_q;
    logic       u_load, u_valid, u_empty;
    logic [MOVE_W*MAX_MOVES-1:0] u_data;
    logic       wd_hit;

`ifdef SCAN_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, wd_run;

    // Counts only while blocked on an external party; any state change restarts it.
    assign wd_run = (state_q == ST_WAIT) || (state_q == ST_OBSERVE) ||
                    ((state_q == ST_ISSUE) && u_valid && !move_ready);
    assign wd_hit = wd_run && (wd_q == TIMEOUT_CYCLES - 1);
    assign wd_d   = (!wd_run || state_d != state_q) ? 32'd0 : wd_q + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_hit)
                timeout_q <= 1'b1;
            else if (state_q == ST_IDLE && start)
                timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        u_load    = 1'b0;
        u_data    = moves;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_REQ;
            ST_REQ:     state_d = ST_WAIT;
            ST_WAIT:    if (new_moves) begin
                            u_load  = 1'b1;
                            state_d = ST_ISSUE;
                        end
            // leave on the edge of the last transfer so observe_req follows it directly
            ST_ISSUE:   if (u_empty)
                            state_d = (counter_q == LAST_STEP) ? ST_FINISH : ST_OBSERVE;
            ST_OBSERVE: if (observe_done) begin
                            state_d   = ST_REQ;
                            counter_d = counter_q + 6'd1;
                        end
            ST_FINISH:  begin
                            state_d   = ST_IDLE;
                            counter_d = '0;
                        end
            default:    state_d = ST_IDLE;
        endcase
        if (wd_hit) begin
            // abort: flush the unpacker so move_valid drops with the state
            state_d   = ST_IDLE;
            counter_d = '0;
            u_load    = 1'b1;
            u_data    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            send_q    <= 1'b0;
            obs_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            send_q    <= (state_d == ST_REQ);
            obs_q     <= (state_d == ST_OBSERVE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_FINISH);
        end
    end

    move_unpacker #(
        .MOVE_W    (MOVE_W),
        .MAX_MOVES (MAX_MOVES)
    ) u_unpack (
        .clock (clock),
        .reset (reset),
        .load  (u_load),
        .data  (u_data),
        .valid (u_valid),
        .ready (move_ready),
        .code  (move),
        .empty (u_empty)
    );

    assign move_valid       = u_valid;
    assign send_setup_moves = send_q;
    assign counter          = counter_q;
    assign observe_req      = obs_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a spin_all/colour-sampler model drives a full scan
// with random batches and random move_ready; expected moves are queued when a
// batch is issued and a separate monitor pops them on every transfer.
module tb_scan_sequencer;

    localparam int NUM_STEPS = 45;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        send_setup_moves;
    logic [5:0]  counter;
    logic        new_moves = 1'b0;
    logic [59:0] moves = '0;
    logic [3:0]  move;
    logic        move_valid;
    logic        move_ready = 1'b0;
    logic        observe_req;
    logic        observe_done = 1'b0;
    logic        busy;
    logic        done;
`ifdef SCAN_WATCHDOG_EN
    logic        timeout;
`endif

    scan_sequencer #(.NUM_STEPS(NUM_STEPS), .MOVE_W(4), .MAX_MOVES(15)) dut (
        .clock            (clk),
        .reset            (rst),
        .start            (start),
        .send_setup_moves (send_setup_moves),
        .counter          (counter),
        .new_moves        (new_moves),
        .moves            (moves),
        .move             (move),
        .move_valid       (move_valid),
        .move_ready       (move_ready),
        .observe_req      (observe_req),
        .observe_done     (observe_done),
        .busy             (busy),
`ifdef SCAN_WATCHDOG_EN
        .timeout          (timeout),
`endif
        .done             (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;                 // index of the most recent rising edge
    int last_xfer_edge = 0;
    int n_req = 0, n_obs = 0, n_done = 0;
    logic obs_prev = 1'b0;
    logic [3:0] sb_q[$];         // expected move codes, in issue order
    bit         ready_pat[$];    // forced move_ready values, one per cycle

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: real moves of a batch, most-significant slot first.
    function automatic void expect_batch(input logic [59:0] b);
        for (int i = 14; i >= 0; i--) begin
            int nib = int'((b >> (4 * i)) & 60'hF);
            if (nib >= 2 && nib <= 13) sb_q.push_back(4'(nib));
        end
    endfunction

    // move_ready: forced pattern if queued, otherwise ~75% ready.
    initial forever begin
        @(posedge clk);
        #2;
        if (ready_pat.size() > 0) move_ready = ready_pat.pop_front();
        else                      move_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: checks every transfer against the scoreboard and stall stability.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_move = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            obs_prev   = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", move_valid, 1);
                chk("stall_move_held", move, prev_move);
            end
            if (move_valid && move_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_move: got code %0d expected none (edge %0d)", move, cyc);
                end else begin
                    chk("move_code", move, sb_q.pop_front());
                    if (sb_q.size() == 0) last_xfer_edge = cyc + 1;
                end
            end
            prev_stall = move_valid && !move_ready;
            prev_move  = move;
            if (send_setup_moves)         n_req++;
            if (observe_req && !obs_prev) n_obs++;
            if (done)                     n_done++;
            obs_prev = observe_req;
        end
    end

    task automatic wait_req(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!send_setup_moves && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = send_setup_moves;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no send_setup_moves expected one within 100 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_send"}, send_setup_moves, 0);
        chk({tag, "_counter"}, counter, 0);
        chk({tag, "_move"}, move, 0);
        chk({tag, "_move_valid"}, move_valid, 0);
        chk({tag, "_observe_req"}, observe_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_scan();
        int exp_req, M, exp_obs, t;
        bit ok, nonempty;
        logic [63:0] rnd;
        logic [59:0] b;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_req = cyc;
        for (int s = 0; s < NUM_STEPS; s++) begin
            wait_req(ok);
            if (!ok) return;
            chk("req_edge", cyc, exp_req);
            chk("req_counter", counter, s);
            chk("req_busy", busy, 1);
            @(negedge clk);
            chk("req_one_cycle", send_setup_moves, 0);
            chk("wait_counter", counter, s);
            // batch selection: directed cases on the first steps, random otherwise
            rnd = {$urandom(), $urandom()};
            case (s)
                0:       b = 60'h0;
                1:       b = 60'h4;
                2:       b = 60'h0000_0000_0000_46B;
                default: b = ($urandom_range(0, 4) == 0) ? (rnd[59:0] & 60'hF0F_00F0_0F00_F00F) : rnd[59:0];
            endcase
            chk("sb_empty_before_batch", sb_q.size(), 0);
            expect_batch(b);
            nonempty = (sb_q.size() > 0);
            @(posedge clk); #1;
            new_moves = 1'b1;
            moves     = b;
            @(posedge clk); #1;
            M         = cyc;
            new_moves = 1'b0;
            moves     = rnd[63:4];  // must be ignored once captured
            if (s == 2) begin
                ready_pat.push_back(1'b1);
                ready_pat.push_back(1'b0);
                ready_pat.push_back(1'b1);
                ready_pat.push_back(1'b1);
            end
            @(negedge clk);
            chk("valid_after_capture", move_valid, nonempty);
            t = 0;
            while (!(observe_req || done) && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("batch_drained", sb_q.size(), 0);
            exp_obs = nonempty ? last_xfer_edge : M + 1;
            chk("end_of_issue_edge", cyc, exp_obs);
            if (s < NUM_STEPS - 1) begin
                chk("observe_req", observe_req, 1);
                chk("no_early_done", done, 0);
                chk("observe_counter", counter, s);
                @(posedge clk);
                @(posedge clk); #1 observe_done = 1'b1;
                @(posedge clk); #1 observe_done = 1'b0;
                exp_req = cyc;
            end else begin
                chk("final_done", done, 1);
                chk("final_no_observe", observe_req, 0);
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_counter", counter, 0);
            end
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        run_scan();
        repeat (3) @(negedge clk);
        chk("total_requests", n_req, NUM_STEPS);
        chk("total_observations", n_obs, NUM_STEPS - 1);
        chk("total_done", n_done, 1);

        // Reset in the middle of a stalled batch.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_req(ok);
        chk("rst_test_counter", counter, 0);
        @(posedge clk);
        @(posedge clk); #1;
        repeat (8) ready_pat.push_back(1'b0);
        new_moves = 1'b1;
        moves     = 60'h456789ABCDEF234;
        @(posedge clk); #1 new_moves = 1'b0;
        @(posedge clk); #1;
        chk("valid_before_reset", move_valid, 1);
        rst = 1'b1;
        #1 check_all_zero("midissue_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        ready_pat.delete();
        sb_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_req(ok);
        chk("restart_counter", counter, 0);
        chk("restart_busy", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish within 2ms");
        $fatal(1);
    end

endmodule
